breakout_score_ctrl: RTL
========================

BREAKOUT_SCORE_CTRL -- requirements
Module: breakout_score_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3, meaning balls per game (1..3).
REQ-002 SHALL have parameter DELAY_TICKS, default 120, meaning timer_tick count held in OVER (2 s at 60 Hz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have port timer_tick  input  1  one-cycle pulse per frame refresh.
REQ-006 SHALL have port btn_start  input  1  one-cycle debounced start pulse.
REQ-007 SHALL have port brick_hit  input  1  one-cycle pulse, brick destroyed.
REQ-008 SHALL have port hit_pts  input  2  points for the brick_hit pulse (0..3).
REQ-009 SHALL have port ball_miss  input  1  one-cycle pulse, ball lost below paddle.
REQ-010 SHALL have port all_cleared  input  1  one-cycle pulse, last brick destroyed.
REQ-011 SHALL have port dig0, dig1  output  4 each  BCD score ones/tens, registered, feeding the text stage.
REQ-012 SHALL have port ball  output  2  balls remaining, registered.
REQ-013 SHALL have port state  output  2  game state code, registered.
REQ-014 SHALL have port gra_still  output  1  1 = graphics frozen, ball parked on paddle.
REQ-015 SHALL have port ball_launch  output  1  one-cycle pulse on every entry to PLAY.

Function
REQ-016 SHALL implement FSM NEWGAME(0), PLAY(1), NEWBALL(2), OVER(3); state output equals the code.
REQ-017 NEWGAME: score forced to 00, ball forced to LIVES, gra_still=1; btn_start -> PLAY.
REQ-018 PLAY: gra_still=0; ball_miss with ball==1 -> OVER and ball=0; ball_miss with ball>1 -> NEWBALL and ball decrements; all_cleared -> OVER.
REQ-019 NEWBALL: gra_still=1, score and ball held; btn_start -> PLAY.
REQ-020 OVER: gra_still=1; delay counter counts timer_tick pulses; on the DELAY_TICKS-th tick -> NEWGAME; btn_start ignored.
REQ-021 Delay counter SHALL clear on entry to OVER and be 0 in every other state.
REQ-022 ball_launch SHALL assert in the cycle after the transition into PLAY is registered, for exactly one cycle.
REQ-023 brick_hit SHALL be honoured only in PLAY; score updates on the next clock edge (latency 1).
REQ-024 BCD add: s=dig0+hit_pts; s>9 -> dig0=s-10 and tens increments; otherwise dig0=s.
REQ-025 Tens overflow (99 + carry) SHALL follow REQ-033.
REQ-026 hit_pts=0 SHALL leave score unchanged.
REQ-027 Same-cycle brick_hit and ball_miss/all_cleared SHALL apply the score update and the state transition in that same edge.
REQ-028 Same-cycle ball_miss and all_cleared: all_cleared wins -> OVER; ball still decrements.
REQ-029 Inputs outside their honoured states SHALL be ignored without side effects.

Reset
REQ-030 reset_n=0 at a clock edge SHALL set state=NEWGAME, dig0=dig1=0, ball=LIVES, delay counter=0, gra_still=1, ball_launch=0.
REQ-031 Reset SHALL override every input in the same cycle, including mid-OVER and mid-PLAY.

Configuration
REQ-032 Macro BREAKOUT_SCORE_SAT_EN SHALL select score overflow behaviour.
REQ-033 Defined: score saturates at 99 and stays there; undefined: score wraps modulo 100 (99+2 -> 01).

Structure
REQ-034 Shared package breakout_pkg SHALL hold the state enum codes, BCD digit width, and default LIVES and DELAY_TICKS.
REQ-035 Sub-module bcd_score_add (2-digit BCD adder with saturate/wrap) SHALL hold the arithmetic; the FSM and counters stay in the top.

Verification
REQ-036 Reset, btn_start, 5 brick_hit pts=3 -> score 15, state=1, ball_launch pulsed once.
REQ-037 Score 98, brick_hit pts=3 -> 99 with BREAKOUT_SCORE_SAT_EN, else 01.
REQ-038 LIVES=3, three ball_miss with btn_start between -> ball 2,1,0, state 2,2,3.
REQ-039 In OVER, 119 ticks -> still 3; 120th tick -> NEWGAME, score 00, ball 3.
REQ-040 Score 07, same-cycle brick_hit pts=2 and ball_miss -> score 09, ball decremented, state=2.
REQ-041 reset_n=0 mid-PLAY at score 42 -> next cycle score 00, state 0, gra_still=1.

Source files
------------

// File: rtl/breakout_pkg.sv
// +----------------------------------------------------------------------------+
// | breakout_pkg                                                               |
// | Shared state codes, BCD digit width and default game parameters.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package breakout_pkg;

  typedef enum logic [1:0] {
    S_NEWGAME = 2'd0,
    S_PLAY    = 2'd1,
    S_NEWBALL = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  localparam int c_bcd_w           = 4;
  localparam int c_def_lives       = 3;
  localparam int c_def_delay_ticks = 120;

endpackage

`default_nettype wire

// File: rtl/bcd_score_add.sv
// +----------------------------------------------------------------------------+
// | bcd_score_add                                                              |
// | Two-digit BCD score plus 0..3 points; 99 overflow wraps modulo 100, or     |
// | saturates at 99 when BREAKOUT_SCORE_SAT_EN is defined.                     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_score_add
  import breakout_pkg::*;
(
  input  logic [c_bcd_w-1:0] dig0,
  input  logic [c_bcd_w-1:0] dig1,
  input  logic [1:0]         pts,
  output logic [c_bcd_w-1:0] sum0,
  output logic [c_bcd_w-1:0] sum1
);

  logic [c_bcd_w:0]   w_s;
  logic [c_bcd_w:0]   w_s_adj;
  logic               w_carry;
  logic [c_bcd_w-1:0] w_ones;

  always_comb begin
    w_s     = {1'b0, dig0} + (c_bcd_w + 1)'(pts);
    w_s_adj = w_s - (c_bcd_w + 1)'(10);
    w_carry = (w_s > (c_bcd_w + 1)'(9));
    w_ones  = w_carry ? w_s_adj[c_bcd_w-1:0] : w_s[c_bcd_w-1:0];
  end

  always_comb begin
    sum0 = w_ones;
    sum1 = dig1;
    if (w_carry) begin
      if (dig1 == c_bcd_w'(9)) begin
`ifdef BREAKOUT_SCORE_SAT_EN
        sum0 = c_bcd_w'(9);
        sum1 = c_bcd_w'(9);
`else
        sum1 = '0;
`endif
      end else begin
        sum1 = dig1 + c_bcd_w'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/breakout_score_ctrl.sv
// +----------------------------------------------------------------------------+
// | breakout_score_ctrl                                                        |
// | Breakout game FSM: score, balls remaining, game-over delay, ball launch.   |
// | Score overflow set by BREAKOUT_SCORE_SAT_EN (see bcd_score_add).           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module breakout_score_ctrl
  import breakout_pkg::*;
#(
  parameter int LIVES       = c_def_lives,
  parameter int DELAY_TICKS = c_def_delay_ticks
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               timer_tick,
  input  logic               btn_start,
  input  logic               brick_hit,
  input  logic [1:0]         hit_pts,
  input  logic               ball_miss,
  input  logic               all_cleared,
  output logic [c_bcd_w-1:0] dig0,
  output logic [c_bcd_w-1:0] dig1,
  output logic [1:0]         ball,
  output logic [1:0]         state,
  output logic               gra_still,
  output logic               ball_launch
);

  localparam int c_dly_w = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS + 1) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_dly_w-1:0] r_dly;
  logic [c_bcd_w-1:0] r_dig0;
  logic [c_bcd_w-1:0] r_dig1;
  logic [1:0]         r_ball;
  logic               r_launch;
  logic [c_bcd_w-1:0] w_sum0;
  logic [c_bcd_w-1:0] w_sum1;
  logic               w_dly_done;

  bcd_score_add u_add (
    .dig0 (r_dig0),
    .dig1 (r_dig1),
    .pts  (hit_pts),
    .sum0 (w_sum0),
    .sum1 (w_sum1)
  );

  assign w_dly_done = timer_tick && (r_dly == c_dly_w'(DELAY_TICKS - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NEWGAME: if (btn_start) w_state_nxt = S_PLAY;
      S_PLAY: begin
        // all_cleared dominates a same-cycle miss; the ball is still spent
        if (all_cleared)
          w_state_nxt = S_OVER;
        else if (ball_miss)
          w_state_nxt = (r_ball == 2'd1) ? S_OVER : S_NEWBALL;
      end
      S_NEWBALL: if (btn_start) w_state_nxt = S_PLAY;
      S_OVER:    if (w_dly_done) w_state_nxt = S_NEWGAME;
      default:   w_state_nxt = S_NEWGAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_NEWGAME;
      r_dly    <= '0;
      r_dig0   <= '0;
      r_dig1   <= '0;
      r_ball   <= 2'(LIVES);
      r_launch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_launch <= (w_state_nxt == S_PLAY) && (r_state != S_PLAY);

      if (w_state_nxt == S_NEWGAME) begin
        r_dig0 <= '0;
        r_dig1 <= '0;
        r_ball <= 2'(LIVES);
      end else if (r_state == S_PLAY) begin
        if (brick_hit) begin
          r_dig0 <= w_sum0;
          r_dig1 <= w_sum1;
        end
        if (ball_miss && (r_ball != 2'd0))
          r_ball <= r_ball - 2'd1;
      end

      // Counter lives only while staying in OVER, so entry and exit both clear it
      if ((r_state == S_OVER) && (w_state_nxt == S_OVER)) begin
        if (timer_tick)
          r_dly <= r_dly + c_dly_w'(1);
      end else begin
        r_dly <= '0;
      end
    end
  end

  assign dig0        = r_dig0;
  assign dig1        = r_dig1;
  assign ball        = r_ball;
  assign state       = r_state;
  assign gra_still   = (r_state != S_PLAY);
  assign ball_launch = r_launch;

endmodule

`default_nettype wire
